dec_onehot_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a built-in index sequencer. It generalises the 2-to-4 enable decoder to N select bits and a programmable active range (LIMIT). The output can be loaded directly from W or stepped up/down with wrap-around. It drives one-hot select lines (bank/phase/row enables) in the datapath, with a glitch-free registered output.

---
 rtl/dec_pkg.sv | 14 +
 rtl/dec_n_to_onehot.sv | 20 ++
 rtl/dec_onehot_seq.sv | 121 ++++++++++++
 tb/tb_dec_onehot_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared command and state encodings for the one-hot index sequencer.
package dec_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;
   localparam logic [1:0] MODE_UP   = 2'b10;
   localparam logic [1:0] MODE_DOWN = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/dec_n_to_onehot.sv
// Generalised enable decoder: N-bit index to 2**N one-hot lines, all-zero when disabled.
module dec_n_to_onehot #(
   parameter int N = 2
) (
   input  logic [N-1:0]      i_w,
   input  logic              i_en,
   output logic [(2**N)-1:0] o_y
);

   // Single-bit select of position i_w, gated by i_en.
   always_comb begin
      o_y = '0;
      if (i_en) begin
         o_y[i_w] = 1'b1;
      end else begin
         o_y = '0;
      end
   end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot decoder with load/step sequencing over a LIMIT-sized range.
module dec_onehot_seq
   import dec_pkg::*;
#(
   parameter int N     = 2,
   parameter int LIMIT = 2**N
) (
   input  logic              i_clock,
   input  logic              i_resetn,
   input  logic              i_en,
   input  logic [1:0]        i_mode,
   input  logic [N-1:0]      i_w,
   output logic [(2**N)-1:0] o_y,
   output logic [N-1:0]      o_idx,
   output logic              o_active,
   output logic              o_wrap,
   output logic              o_err
);

   localparam logic [N-1:0] IDX_MAX = N'(LIMIT - 1);
   localparam logic [N-1:0] IDX_ONE = N'(1);

   state_t              r_state;
   logic [N-1:0]        r_idx;
   logic [(2**N)-1:0]   r_y;
   logic                r_wrap;
   logic                r_err;

   state_t              w_state_nx;
   logic [N-1:0]        w_idx_nx;
   logic [(2**N)-1:0]   w_y_nx;
   logic                w_wrap_nx;
   logic                w_err_nx;
   logic                w_dec_en;
   logic                w_load_ok;

   assign w_load_ok = (32'(i_w) < 32'(LIMIT));

   // Next-state, next-index and pulse decode for the current command.
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_wrap_nx  = 1'b0;
      w_err_nx   = 1'b0;
      w_dec_en   = 1'b0;
      if (i_en) begin
         case (i_mode)
            MODE_HOLD: begin
               w_idx_nx = r_idx;
            end
            MODE_LOAD: begin
               if (w_load_ok) begin
                  w_idx_nx   = i_w;
                  w_state_nx = ST_ACTIVE;
               end else begin
                  w_err_nx = 1'b1;
               end
            end
            MODE_UP: begin
               // Wrap is taken against LIMIT-1, not natural N-bit overflow.
               if (r_state == ST_IDLE) begin
                  w_idx_nx   = '0;
                  w_state_nx = ST_ACTIVE;
               end else if (r_idx == IDX_MAX) begin
                  w_idx_nx  = '0;
                  w_wrap_nx = 1'b1;
               end else begin
                  w_idx_nx = r_idx + IDX_ONE;
               end
            end
            MODE_DOWN: begin
               if (r_state == ST_IDLE) begin
                  w_idx_nx   = IDX_MAX;
                  w_state_nx = ST_ACTIVE;
               end else if (r_idx == '0) begin
                  w_idx_nx  = IDX_MAX;
                  w_wrap_nx = 1'b1;
               end else begin
                  w_idx_nx = r_idx - IDX_ONE;
               end
            end
            default: begin
               w_idx_nx = r_idx;
            end
         endcase
         w_dec_en = (w_state_nx == ST_ACTIVE);
      end else begin
         w_dec_en = 1'b0;
      end
   end

   dec_n_to_onehot #(.N(N)) u_dec (
      .i_w  (w_idx_nx),
      .i_en (w_dec_en),
      .o_y  (w_y_nx)
   );

   // Output and state registers; asynchronous clear drops any pending pulse.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_y     <= '0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_y     <= w_y_nx;
         r_wrap  <= w_wrap_nx;
         r_err   <= w_err_nx;
      end
   end

   assign o_y      = r_y;
   assign o_idx    = r_idx;
   assign o_active = (r_state == ST_ACTIVE);
   assign o_wrap   = r_wrap;
   assign o_err    = r_err;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Directed scoreboard bench for dec_onehot_seq across three N/LIMIT configurations.
module tb_dec_onehot_seq;
   import dec_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rn_a, en_a, act_a, wrap_a, err_a;
   logic [1:0] mode_a, w_a, idx_a;
   logic [3:0] y_a;

   logic       rn_b, en_b, act_b, wrap_b, err_b;
   logic [1:0] mode_b, w_b, idx_b;
   logic [3:0] y_b;

   logic       rn_c, en_c, act_c, wrap_c, err_c;
   logic [1:0] mode_c;
   logic [2:0] w_c, idx_c;
   logic [7:0] y_c;

   dec_onehot_seq #(.N(2), .LIMIT(4)) u_a (
      .i_clock(clk), .i_resetn(rn_a), .i_en(en_a), .i_mode(mode_a), .i_w(w_a),
      .o_y(y_a), .o_idx(idx_a), .o_active(act_a), .o_wrap(wrap_a), .o_err(err_a));

   dec_onehot_seq #(.N(2), .LIMIT(3)) u_b (
      .i_clock(clk), .i_resetn(rn_b), .i_en(en_b), .i_mode(mode_b), .i_w(w_b),
      .o_y(y_b), .o_idx(idx_b), .o_active(act_b), .o_wrap(wrap_b), .o_err(err_b));

   dec_onehot_seq #(.N(3), .LIMIT(8)) u_c (
      .i_clock(clk), .i_resetn(rn_c), .i_en(en_c), .i_mode(mode_c), .i_w(w_c),
      .o_y(y_c), .o_idx(idx_c), .o_active(act_c), .o_wrap(wrap_c), .o_err(err_c));

   typedef struct {
      int         inst;
      logic [7:0] y;
      logic [2:0] idx;
      logic       act;
      logic       wrap;
      logic       err;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic drive(input int inst, input logic en, input logic [1:0] mode, input logic [2:0] w);
      case (inst)
         0: begin en_a = en; mode_a = mode; w_a = w[1:0]; end
         1: begin en_b = en; mode_b = mode; w_b = w[1:0]; end
         2: begin en_c = en; mode_c = mode; w_c = w; end
         default: ;
      endcase
   endtask

   task automatic push(input int inst, input logic [7:0] y, input logic [2:0] idx,
                       input logic act, input logic wrap, input logic err, input string tag);
      exp_t e;
      e.inst = inst; e.y = y; e.idx = idx; e.act = act; e.wrap = wrap; e.err = err; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic check_now();
      exp_t       e;
      logic [7:0] oy;
      logic [2:0] oi;
      logic       oa, ow, oe;
      e = sb_q.pop_front();
      case (e.inst)
         0: begin oy = {4'h0, y_a}; oi = {1'b0, idx_a}; oa = act_a; ow = wrap_a; oe = err_a; end
         1: begin oy = {4'h0, y_b}; oi = {1'b0, idx_b}; oa = act_b; ow = wrap_b; oe = err_b; end
         default: begin oy = y_c; oi = idx_c; oa = act_c; ow = wrap_c; oe = err_c; end
      endcase
      n_cmp++;
      assert (oy === e.y) else begin
         n_bad++; $error("FAIL %s.y observed=%h expected=%h", e.tag, oy, e.y);
      end
      n_cmp++;
      assert (oi === e.idx) else begin
         n_bad++; $error("FAIL %s.idx observed=%0d expected=%0d", e.tag, oi, e.idx);
      end
      n_cmp++;
      assert (oa === e.act) else begin
         n_bad++; $error("FAIL %s.active observed=%b expected=%b", e.tag, oa, e.act);
      end
      n_cmp++;
      assert (ow === e.wrap) else begin
         n_bad++; $error("FAIL %s.wrap observed=%b expected=%b", e.tag, ow, e.wrap);
      end
      n_cmp++;
      assert (oe === e.err) else begin
         n_bad++; $error("FAIL %s.err observed=%b expected=%b", e.tag, oe, e.err);
      end
   endtask

   // Drive one command, expect its result one edge later, then park the instance on HOLD.
   task automatic step(input int inst, input logic en, input logic [1:0] mode, input logic [2:0] w,
                       input logic [7:0] y, input logic [2:0] idx, input logic act,
                       input logic wrap, input logic err, input string tag);
      drive(inst, en, mode, w);
      push(inst, y, idx, act, wrap, err, tag);
      @(posedge clk);
      #1;
      check_now();
      drive(inst, 1'b1, MODE_HOLD, 3'd0);
   endtask

   initial begin
      rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
      drive(0, 1'b1, MODE_HOLD, 3'd0);
      drive(1, 1'b1, MODE_HOLD, 3'd0);
      drive(2, 1'b1, MODE_HOLD, 3'd0);
      #2;
      push(0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "rst_a"); check_now();
      push(1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "rst_b"); check_now();
      push(2, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "rst_c"); check_now();
      @(negedge clk);
      rn_a = 1'b1; rn_b = 1'b1; rn_c = 1'b1;

      // IDLE with HOLD stays dark
      for (int i = 0; i < 3; i++)
         step(0, 1'b1, MODE_HOLD, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "idle_hold");

      // load then step up across the LIMIT=4 boundary
      step(0, 1'b1, MODE_LOAD, 3'd2, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, "load2");
      step(0, 1'b1, MODE_UP,   3'd0, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0, "up3");
      step(0, 1'b1, MODE_UP,   3'd0, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0, "up_wrap");
      step(0, 1'b1, MODE_HOLD, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, "wrap_once");

      // LIMIT=3: DOWN from IDLE, wrap at 0, illegal load
      step(1, 1'b1, MODE_DOWN, 3'd0, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, "b_down_idle");
      step(1, 1'b1, MODE_DOWN, 3'd0, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, "b_down1");
      step(1, 1'b1, MODE_DOWN, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, "b_down0");
      step(1, 1'b1, MODE_DOWN, 3'd0, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, "b_down_wrap");
      step(1, 1'b1, MODE_LOAD, 3'd3, 8'h04, 3'd2, 1'b1, 1'b0, 1'b1, "b_load_bad");
      step(1, 1'b1, MODE_HOLD, 3'd0, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0, "b_err_once");

      // En=0 freezes index and blanks Y
      step(0, 1'b1, MODE_LOAD, 3'd1, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, "load1");
      step(0, 1'b0, MODE_UP,   3'd0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, "en0_a");
      step(0, 1'b0, MODE_UP,   3'd0, 8'h00, 3'd1, 1'b1, 1'b0, 1'b0, "en0_b");
      step(0, 1'b1, MODE_HOLD, 3'd0, 8'h02, 3'd1, 1'b1, 1'b0, 1'b0, "en1_hold");

      // N=3 full walk and wrap, then DOWN wrap from 0
      for (int k = 0; k < 8; k++)
         step(2, 1'b1, MODE_UP, 3'd0, 8'h01 << k, 3'(k), 1'b1, 1'b0, 1'b0, "c_walk");
      step(2, 1'b1, MODE_UP,   3'd0, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0, "c_wrap");
      step(2, 1'b1, MODE_DOWN, 3'd0, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0, "c_down_wrap");

      // asynchronous reset while a Wrap pulse is visible
      step(0, 1'b1, MODE_LOAD, 3'd3, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0, "load3");
      drive(0, 1'b1, MODE_UP, 3'd0);
      push(0, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0, "pre_rst");
      @(posedge clk);
      #1;
      check_now();
      drive(0, 1'b1, MODE_HOLD, 3'd0);
      #2;
      rn_a = 1'b0;
      #1;
      push(0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "async_rst"); check_now();
      @(negedge clk);
      rn_a = 1'b1;
      step(0, 1'b1, MODE_UP, 3'd0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, "post_rst_up");

      n_cmp++;
      assert (sb_q.size() == 0) else begin
         n_bad++; $error("FAIL sb_empty observed=%0d expected=0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
